mem_ram_stall: RTL and testbench

Parametrised, word-organised, big-endian data memory with a req/ready/done handshake and a configurable access latency. It is the successor to the single-cycle 16-bit RAM and serves as the instruction and data memory behind the fetch and memory stages. Those stages must stall on `ready`/`done` instead of assuming a zero-wait response.

---
 rtl/mem_ram_stall_pkg.sv | 40 ++++
 rtl/mem_ram_stall_if.sv | 20 ++
 rtl/mem_ram_stall_array.sv | 26 ++
 rtl/mem_ram_stall.sv | 153 +++++++++++++++
 tb/tb_mem_ram_stall.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/mem_ram_stall_pkg.sv
// Shared types and lane-steering helpers for the stalling data memory.
// MEM_UNALIGNED_EN adds the SPLIT state for accesses that straddle two words.
package mem_pkg;

  localparam int MAX_NB = 32;
  localparam int MAX_W  = 8 * MAX_NB;

`ifdef MEM_UNALIGNED_EN
  typedef enum logic [1:0] {IDLE, BUSY, SPLIT} state_t;
`else
  typedef enum logic [1:0] {IDLE, BUSY} state_t;
`endif

  typedef struct packed {
    logic [MAX_NB-1:0] be0;
    logic [MAX_NB-1:0] be1;
    logic [MAX_W-1:0]  d0;
    logic [MAX_W-1:0]  d1;
  } lane_map_t;

  // Lane NB-1 is the byte at the lowest address, so the first word takes the
  // request shifted down by the offset and the second word takes the spill-over.
  function automatic lane_map_t lane_map(input int unsigned nb, input int unsigned off,
                                         input logic [MAX_NB-1:0] be,
                                         input logic [MAX_W-1:0] din);
    lane_map_t m;
    m.be0 = be >> off;
    m.d0  = din >> (8 * off);
    m.be1 = (off == 0) ? '0 : be << (nb - off);
    m.d1  = (off == 0) ? '0 : din << (8 * (nb - off));
    return m;
  endfunction

  function automatic logic [MAX_W-1:0] rd_merge(input int unsigned nb, input int unsigned off,
                                                input logic [MAX_W-1:0] w0,
                                                input logic [MAX_W-1:0] w1);
    return (off == 0) ? w0 : ((w0 << (8 * off)) | (w1 >> (8 * (nb - off))));
  endfunction

endpackage

// File: rtl/mem_ram_stall_if.sv
// Request/completion bus between a pipeline stage (master) and the memory (slave).
interface mem_ram_stall_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16
);
  logic                  req;
  logic                  wr;
  logic [ADDR_W-1:0]     addr;
  logic [DATA_W-1:0]     data_in;
  logic [DATA_W/8-1:0]   byte_en;
  logic                  ready;
  logic                  done;
  logic [DATA_W-1:0]     data_out;
  logic                  err;

  modport master (output req, wr, addr, data_in, byte_en,
                  input  ready, done, data_out, err);
  modport slave  (input  req, wr, addr, data_in, byte_en,
                  output ready, done, data_out, err);
endinterface

// File: rtl/mem_ram_stall_array.sv
// Word array: asynchronous read, synchronous per-lane write, no reset.
module mem_ram_array #(
  parameter int DATA_W      = 16,
  parameter int DEPTH_WORDS = 32768
) (
  input  logic                           clk,
  input  logic [$clog2(DEPTH_WORDS)-1:0] addr_i,
  input  logic                           we_i,
  input  logic [DATA_W/8-1:0]            be_i,
  input  logic [DATA_W-1:0]              wdata_i,
  output logic [DATA_W-1:0]              rdata_o
);
  localparam int NB = DATA_W / 8;

  logic [DATA_W-1:0] mem [DEPTH_WORDS];

  assign rdata_o = mem[addr_i];

  always_ff @(posedge clk) begin
    if (we_i) begin
      for (int i = 0; i < NB; i++) begin
        if (be_i[i]) mem[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
      end
    end
  end
endmodule

// File: rtl/mem_ram_stall.sv
// Big-endian word memory with req/ready/done handshake and fixed access latency.
// Define MEM_UNALIGNED_EN to allow accesses that straddle two words.
module mem_ram_stall
  import mem_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 16,
  parameter int DEPTH_WORDS = 32768,
  parameter int LATENCY     = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  mem_ram_stall_if.slave  bus
);
  localparam int NB    = DATA_W / 8;
  localparam int OFF_W = $clog2(NB);
  localparam int AW    = $clog2(DEPTH_WORDS);
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  state_t              state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                wr_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   din_q;
  logic [NB-1:0]       be_q;
  logic [DATA_W-1:0]   dout_q;
  logic                done_q;
  logic                err_q;

  logic [OFF_W-1:0]    off;
  logic [31:0]         idx0;
  logic                unaligned;
  logic                acc_err;
  logic                last_busy;
  logic [AW-1:0]       arr_addr;
  logic                arr_we;
  logic [NB-1:0]       arr_be;
  logic [DATA_W-1:0]   arr_wdata;
  logic [DATA_W-1:0]   arr_rdata;

  assign off       = addr_q[OFF_W-1:0];
  assign idx0      = 32'(addr_q >> OFF_W);
  assign unaligned = (off != '0);
  assign last_busy = (state_q == BUSY) && (cnt_q == '0);

`ifdef MEM_UNALIGNED_EN
  logic [31:0]         idx1;
  lane_map_t           lm;
  logic [MAX_W-1:0]    merged;
  logic [DATA_W-1:0]   part_q;

  assign idx1   = idx0 + 32'd1;
  assign lm     = lane_map(NB, 32'(off), MAX_NB'(be_q), MAX_W'(din_q));
  assign merged = rd_merge(NB, 32'(off), MAX_W'(part_q), MAX_W'(arr_rdata));

  always_comb begin
    acc_err   = (idx0 >= 32'(DEPTH_WORDS)) || (unaligned && (idx1 >= 32'(DEPTH_WORDS)));
    arr_addr  = idx0[AW-1:0];
    arr_be    = lm.be0[NB-1:0];
    arr_wdata = lm.d0[DATA_W-1:0];
    arr_we    = wr_q && last_busy && !acc_err;
    if (state_q == SPLIT) begin
      arr_addr  = idx1[AW-1:0];
      arr_be    = lm.be1[NB-1:0];
      arr_wdata = lm.d1[DATA_W-1:0];
      arr_we    = wr_q;
    end
  end
`else
  always_comb begin
    acc_err   = (idx0 >= 32'(DEPTH_WORDS)) || unaligned;
    arr_addr  = idx0[AW-1:0];
    arr_be    = be_q;
    arr_wdata = din_q;
    arr_we    = wr_q && last_busy && !acc_err;
  end
`endif

  mem_ram_array #(.DATA_W(DATA_W), .DEPTH_WORDS(DEPTH_WORDS)) u_array (
    .clk     (clk),
    .addr_i  (arr_addr),
    .we_i    (arr_we),
    .be_i    (arr_be),
    .wdata_i (arr_wdata),
    .rdata_o (arr_rdata)
  );

  // Memory is only touched in the last BUSY cycle (and SPLIT), so an async
  // reset before that edge drops the request without any write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      wr_q    <= 1'b0;
      addr_q  <= '0;
      din_q   <= '0;
      be_q    <= '0;
      dout_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
`ifdef MEM_UNALIGNED_EN
      part_q  <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.req) begin
            wr_q    <= bus.wr;
            addr_q  <= bus.addr;
            din_q   <= bus.data_in;
            be_q    <= bus.byte_en;
            cnt_q   <= CNT_W'(LATENCY - 1);
            state_q <= BUSY;
          end
        end
        BUSY: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - CNT_W'(1);
          end else if (acc_err) begin
            done_q  <= 1'b1;
            err_q   <= 1'b1;
            dout_q  <= '0;
            state_q <= IDLE;
`ifdef MEM_UNALIGNED_EN
          end else if (unaligned) begin
            part_q  <= arr_rdata;
            state_q <= SPLIT;
`endif
          end else begin
            done_q  <= 1'b1;
            if (!wr_q) dout_q <= arr_rdata;
            state_q <= IDLE;
          end
        end
`ifdef MEM_UNALIGNED_EN
        SPLIT: begin
          done_q  <= 1'b1;
          if (!wr_q) dout_q <= merged[DATA_W-1:0];
          state_q <= IDLE;
        end
`endif
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.ready    = (state_q == IDLE);
  assign bus.done     = done_q;
  assign bus.err      = err_q;
  assign bus.data_out = dout_q;
endmodule

// File: tb/tb_mem_ram_stall.sv
// Randomized bench for mem_ram_stall against a byte-addressed reference model.
module tb_mem_ram_stall;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 16;
  localparam int DEPTH  = 32;
  localparam int LAT    = 2;
  localparam int NBYTES = DEPTH * 2;
`ifdef MEM_UNALIGNED_EN
  localparam bit UNALIGNED = 1'b1;
`else
  localparam bit UNALIGNED = 1'b0;
`endif

  logic clk;
  logic rst_n;

  mem_ram_stall_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  mem_ram_stall #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH_WORDS(DEPTH), .LATENCY(LAT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0]  mem_m [NBYTES];
  logic [15:0] dout_m;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic bit model_err(input logic [15:0] a);
    int idx;
    idx = int'(a) / 2;
    if (idx >= DEPTH) return 1'b1;
    if (a[0]) begin
      if (!UNALIGNED) return 1'b1;
      if (idx + 1 >= DEPTH) return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic wait_ready();
    int n = 0;
    while (!bus.ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check_eq("ready_wait", bus.ready, 1);
  endtask

  // One transaction: checks latency, ready/err during the wait, then done/err/data_out.
  task automatic access(input bit w, input logic [15:0] a, input logic [15:0] d,
                        input logic [1:0] be);
    int  n;
    bit  got;
    bit  e;
    int  exp_lat;
    @(negedge clk);
    check_eq("done_pulse", bus.done, 0);
    wait_ready();
    bus.req     = 1'b1;
    bus.wr      = w;
    bus.addr    = a;
    bus.data_in = d;
    bus.byte_en = be;
    @(posedge clk);
    #1 bus.req = 1'b0;
    e       = model_err(a);
    exp_lat = LAT + 1 + ((UNALIGNED && a[0] && !e) ? 1 : 0);
    n   = 0;
    got = 1'b0;
    while (!got && n < 20) begin
      @(negedge clk);
      n++;
      if (bus.done) got = 1'b1;
      else begin
        check_eq("ready_low", bus.ready, 0);
        check_eq("err_idle", bus.err, 0);
      end
    end
    check_eq("done_seen", got, 1);
    check_eq("latency", n, exp_lat);
    check_eq("ready_at_done", bus.ready, 1);
    if (e) dout_m = 16'h0000;
    else if (w) begin
      if (be[1]) mem_m[int'(a)]     = d[15:8];
      if (be[0]) mem_m[int'(a) + 1] = d[7:0];
    end else begin
      dout_m = {mem_m[int'(a)], mem_m[int'(a) + 1]};
    end
    check_eq("err", bus.err, e);
    check_eq("data_out", bus.data_out, dout_m);
  endtask

  initial begin
    int acc[$];
    logic [15:0] a;
    rst_n       = 1'b0;
    bus.req     = 1'b0;
    bus.wr      = 1'b0;
    bus.addr    = '0;
    bus.data_in = '0;
    bus.byte_en = '0;
    dout_m      = 16'h0000;
    repeat (3) @(negedge clk);
    check_eq("rst_ready", bus.ready, 1);
    check_eq("rst_done", bus.done, 0);
    check_eq("rst_err", bus.err, 0);
    check_eq("rst_data_out", bus.data_out, 0);
    rst_n = 1'b1;

    for (int i = 0; i < DEPTH; i++) begin
      access(1'b1, 16'(2 * i), (i == 16) ? 16'h5555 : 16'($urandom), 2'b11);
    end

    access(1'b1, 16'h0010, 16'hBEEF, 2'b11);
    access(1'b0, 16'h0010, 16'h0000, 2'b00);
    check_eq("t1_beef", bus.data_out, 16'hBEEF);
    access(1'b1, 16'h0010, 16'h1234, 2'b01);
    access(1'b0, 16'h0010, 16'h0000, 2'b00);
    check_eq("t2_be34", bus.data_out, 16'hBE34);
    access(1'b1, 16'h0012, 16'h5678, 2'b11);
    access(1'b0, 16'h0011, 16'h0000, 2'b00);
    check_eq("t3_unaligned", bus.data_out, UNALIGNED ? 16'h3456 : 16'h0000);
    access(1'b0, 16'h0010, 16'h0000, 2'b00);
    check_eq("t3_follow", bus.data_out, 16'hBE34);
    access(1'b0, 16'h0040, 16'h0000, 2'b00);
    check_eq("t6_range_err", bus.err, 1);
    access(1'b0, 16'h003F, 16'h0000, 2'b00);

    for (int i = 0; i < 40; i++) begin
      a = 16'($urandom_range(0, 16'h47));
      access(1'($urandom), a, 16'($urandom), 2'($urandom));
    end

    // Reset in the middle of a write must not touch the array.
    access(1'b1, 16'h0020, 16'h5555, 2'b11);
    @(negedge clk);
    wait_ready();
    bus.req     = 1'b1;
    bus.wr      = 1'b1;
    bus.addr    = 16'h0020;
    bus.data_in = 16'hAAAA;
    bus.byte_en = 2'b11;
    @(posedge clk);
    #1 bus.req = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_eq("midrst_ready", bus.ready, 1);
    check_eq("midrst_done", bus.done, 0);
    check_eq("midrst_err", bus.err, 0);
    check_eq("midrst_data_out", bus.data_out, 0);
    dout_m = 16'h0000;
    @(negedge clk);
    rst_n = 1'b1;
    access(1'b0, 16'h0020, 16'h0000, 2'b00);
    check_eq("midrst_no_write", bus.data_out != 16'hAAAA, 1);

    // Back-to-back reads with req held high.
    @(negedge clk);
    wait_ready();
    bus.req  = 1'b1;
    bus.wr   = 1'b0;
    bus.addr = 16'h0010;
    for (int c = 0; c < 14; c++) begin
      if (bus.ready) acc.push_back(c);
      @(negedge clk);
    end
    bus.req = 1'b0;
    check_eq("b2b_count", acc.size(), 5);
    for (int i = 1; i < acc.size(); i++) check_eq("b2b_gap", acc[i] - acc[i-1], LAT + 1);
    wait_ready();
    dout_m = {mem_m[16], mem_m[17]};
    check_eq("b2b_data", bus.data_out, dout_m);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
